// File: rtl/fb_coef_sched.sv
// Round-robin scheduler sharing one combinational coefficient ROM among NREQ burst requesters.
// Streams registered coefficients over a valid/ready handshake, each beat tagged with its requester id.
module fb_coef_sched #(
    parameter int unsigned WIDTH_A = 12,
    parameter int unsigned DEPTH   = 120,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned ID_W    = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH_A-1:0]  req_base,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [WIDTH_A-1:0]       rom_addr,
    input  logic [15:0]              rom_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_coef,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_last,
    output logic                     busy,
    output logic                     err_range
);

    localparam int unsigned SUM_W = ((WIDTH_A > LEN_W) ? WIDTH_A : LEN_W) + 1;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t               state, state_d;
    logic [ID_W-1:0]      rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [WIDTH_A-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]     remain_q, remain_d;
    logic                 out_valid_d, out_last_d, err_range_d;
    logic [15:0]          out_coef_d;
    logic [ID_W-1:0]      out_id_d;

    logic [ID_W-1:0]      grant;
    logic                 grant_ok;
    logic [WIDTH_A-1:0]   base_sel;
    logic [LEN_W-1:0]     len_sel;
    logic [SUM_W-1:0]     end_addr;
    logic                 bad_req;
    logic                 accept;
    logic                 load;
    int                   idx;

    // Round-robin search starting at rr_ptr; descending loop lets the nearest requester win.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        idx      = 0;
        base_sel = '0;
        len_sel  = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % int'(NREQ);
            if (req_valid[ID_W'(idx)]) begin
                grant    = ID_W'(idx);
                grant_ok = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ID_W'(i) == grant) begin
                base_sel = req_base[i*WIDTH_A +: WIDTH_A];
                len_sel  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && grant_ok) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Range check is done one bit wider than either operand so base+len never wraps.
    assign end_addr = SUM_W'(base_sel) + SUM_W'(len_sel);
    assign bad_req  = (len_sel == '0) || (end_addr > SUM_W'(DEPTH));
    assign accept   = (state == IDLE) && grant_ok;
    assign load     = (state == BURST) && (!out_valid || out_ready);

    assign rom_addr = addr_q;
    assign busy     = (state != IDLE) || out_valid;

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        id_d        = id_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        out_valid_d = out_valid;
        out_coef_d  = out_coef;
        out_id_d    = out_id;
        out_last_d  = out_last;
        err_range_d = 1'b0;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    rr_ptr_d = (grant == ID_W'(NREQ - 1)) ? '0 : grant + ID_W'(1);
                    id_d     = grant;
                    if (bad_req) begin
                        err_range_d = 1'b1;
                    end else begin
                        state_d  = BURST;
                        addr_d   = base_sel;
                        remain_d = len_sel;
                    end
                end
            end
            BURST: begin
                if (load) begin
                    out_coef_d  = rom_coef;
                    out_id_d    = id_q;
                    out_last_d  = (remain_q == LEN_W'(1));
                    out_valid_d = 1'b1;
                    remain_d    = remain_q - LEN_W'(1);
                    // Keep the final address on rom_addr once the burst is done.
                    if (remain_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + WIDTH_A'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            remain_q  <= '0;
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            err_range <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            out_valid <= out_valid_d;
            out_coef  <= out_coef_d;
            out_id    <= out_id_d;
            out_last  <= out_last_d;
            err_range <= err_range_d;
        end
    end

endmodule

// File: tb/tb_fb_coef_sched.sv
// Testbench for fb_coef_sched: table of single bursts, hand-written corner sequences and
// randomized traffic checked against a burst-level scoreboard model.
module tb_fb_coef_sched;

    localparam int unsigned WIDTH_A = 12;
    localparam int unsigned DEPTH   = 120;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned ID_W    = 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH_A-1:0] req_base;
    logic [NREQ*LEN_W-1:0]   req_len;
    logic [WIDTH_A-1:0]      rom_addr;
    logic [15:0]             rom_coef;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [15:0]             out_coef;
    logic [ID_W-1:0]         out_id;
    logic                    out_last;
    logic                    busy;
    logic                    err_range;

    logic [WIDTH_A-1:0] b_arr [NREQ];
    logic [LEN_W-1:0]   l_arr [NREQ];

    always #5 clk = ~clk;

    fb_coef_sched #(.WIDTH_A(WIDTH_A), .DEPTH(DEPTH), .NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_len(req_len),
        .rom_addr(rom_addr), .rom_coef(rom_coef),
        .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
        .out_id(out_id), .out_last(out_last), .busy(busy), .err_range(err_range)
    );

    function automatic logic [15:0] rom_f(input int a);
        return 16'((a * 2477) ^ 16'hC35A);
    endfunction

    assign rom_coef = rom_f(int'(rom_addr));

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_base[i*WIDTH_A +: WIDTH_A] = b_arr[i];
            req_len[i*LEN_W +: LEN_W]      = l_arr[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // out_ready driver: 0 = always 1, 1 = random, 2 = repeating 1,0,0,1
    int   rmode = 0;
    int   rcyc  = 0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            case (rmode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = pat[rcyc % 4];
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard: expected beat stream built from accepted requests at burst level.
    typedef struct packed {
        logic [15:0]     coef;
        logic [ID_W-1:0] id;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    int    acc_ids[$];
    int    rr_m = 0;
    int    beats_seen = 0;
    int    err_seen = 0;
    logic  err_due = 1'b0;
    logic  pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [15:0] pc = '0;
    logic [ID_W-1:0] pid = '0;

    always @(negedge clk) begin
        beat_t e;
        int g, eg, b, l;
        if (rst) begin
            exp_q.delete();
            rr_m    = 0;
            err_due = 1'b0;
            pv      = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_coef", 32'(out_coef), 32'(pc));
                chk("hold_id", 32'(out_id), 32'(pid));
                chk("hold_last", 32'(out_last), 32'(pl));
            end
            chk("err_range", 32'(err_range), 32'(err_due));
            err_due = 1'b0;
            if (err_range) err_seen++;
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            chk("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
            if (out_valid && out_ready) begin
                beats_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got coef %0h id %0d, required no beat", out_coef, out_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_coef", 32'(out_coef), 32'(e.coef));
                    chk("beat_id", 32'(out_id), 32'(e.id));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                end
            end
            if (|(req_valid & req_ready)) begin
                g = 0;
                for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) g = i;
                eg = -1;
                for (int k = 0; k < int'(NREQ); k++)
                    if (eg < 0 && req_valid[(rr_m + k) % int'(NREQ)]) eg = (rr_m + k) % int'(NREQ);
                chk("grant_rr", 32'(g), 32'(eg));
                acc_ids.push_back(g);
                rr_m = (g + 1) % int'(NREQ);
                b = int'(b_arr[g]);
                l = int'(l_arr[g]);
                if (l == 0 || b + l > int'(DEPTH)) begin
                    err_due = 1'b1;
                end else begin
                    for (int j = 0; j < l; j++)
                        exp_q.push_back('{coef: rom_f(b + j), id: ID_W'(g), last: (j == l - 1)});
                end
            end
            pv  = out_valid;
            pr  = out_ready;
            pc  = out_coef;
            pid = out_id;
            pl  = out_last;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // Raise one request, wait for its grant, drop it after the accepting edge.
    task automatic post(input int id, input int base, input int len);
        bit got;
        got = 1'b0;
        nxt();
        b_arr[id] = WIDTH_A'(base);
        l_arr[id] = LEN_W'(len);
        req_valid[id] = 1'b1;
        for (int c = 0; c < 300 && !got; c++) begin
            mid();
            if (req_ready[id]) got = 1'b1;
            else nxt();
        end
        nxt();
        req_valid[id] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL post_accept: requester %0d got no grant, required grant within 300 cycles", id);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 2000 && !idle; c++) begin
            mid();
            if (!busy) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL idle_timeout: busy still 1, required 0 within 2000 cycles");
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        int id;
        int base;
        int len;
        int exp_err;
        int exp_beats;
    } vec_t;

    initial begin
        vec_t vecs [12];
        int eb, ee, n0;
        logic [NREQ-1:0] acc_prev;

        for (int i = 0; i < int'(NREQ); i++) begin
            b_arr[i] = '0;
            l_arr[i] = '0;
        end

        // Reset state
        rst = 1'b1;
        nxt();
        nxt();
        mid();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_range), 32'd0);
        chk("rst_coef", 32'(out_coef), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Single burst with exact latency
        rmode = 0;
        post(0, 5, 3);
        mid();
        chk("t1_valid_t1", 32'(out_valid), 32'd0);
        chk("t1_rom_addr", 32'(rom_addr), 32'd5);
        for (int j = 0; j < 3; j++) begin
            nxt();
            mid();
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_coef", 32'(out_coef), 32'(rom_f(5 + j)));
            chk("t1_id", 32'(out_id), 32'd0);
            chk("t1_last", 32'(out_last), 32'(j == 2));
        end
        nxt();
        mid();
        chk("t1_valid_after", 32'(out_valid), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Backpressure pattern 1,0,0,1
        rmode = 2;
        eb = beats_seen;
        post(0, 0, 4);
        wait_idle();
        chk("t2_beats", 32'(beats_seen - eb), 32'd4);
        rmode = 0;

        // Contention from reset
        do_reset();
        acc_ids.delete();
        b_arr[0] = WIDTH_A'(10); l_arr[0] = LEN_W'(2);
        b_arr[1] = WIDTH_A'(20); l_arr[1] = LEN_W'(2);
        req_valid = '1;
        for (int c = 0; c < 100 && acc_ids.size() < 4; c++) begin
            mid();
            if (acc_ids.size() < 4) nxt();
        end
        nxt();
        req_valid = '0;
        chk("t3_accepts", 32'(acc_ids.size()), 32'd4);
        for (int k = 0; k < 4 && k < acc_ids.size(); k++)
            chk("t3_order", 32'(acc_ids[k]), 32'(k % 2));
        wait_idle();

        // len==0 advances rr pointer
        do_reset();
        ee = err_seen;
        post(0, 5, 0);
        nxt();
        mid();
        chk("t5_err", 32'(err_seen - ee), 32'd1);
        acc_ids.delete();
        nxt();
        b_arr[0] = WIDTH_A'(1); l_arr[0] = LEN_W'(1);
        b_arr[1] = WIDTH_A'(2); l_arr[1] = LEN_W'(1);
        req_valid = '1;
        for (int c = 0; c < 20 && acc_ids.size() == 0; c++) begin
            mid();
            if (acc_ids.size() == 0) nxt();
        end
        nxt();
        req_valid = '0;
        chk("t5_grant_other", 32'(acc_ids.size() > 0 ? acc_ids[0] : -1), 32'd1);
        wait_idle();

        // Reset mid-burst
        n0 = beats_seen;
        post(1, 30, 5);
        for (int c = 0; c < 50 && beats_seen - n0 < 2; c++) mid();
        nxt();
        rst = 1'b1;
        req_valid[0] = 1'b1;
        nxt();
        mid();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd0);
        nxt();
        rst = 1'b0;
        req_valid = '0;
        eb = beats_seen;
        post(0, 40, 2);
        wait_idle();
        chk("t6_new_beats", 32'(beats_seen - eb), 32'd2);

        // Table of single bursts including range boundaries
        vecs = '{
            '{0, 0, 1, 0, 1},     '{1, 119, 1, 0, 1},  '{0, 118, 2, 0, 2},   '{1, 118, 3, 1, 0},
            '{0, 117, 3, 0, 3},   '{1, 0, 120, 0, 120}, '{0, 0, 121, 1, 0},  '{1, 5, 0, 1, 0},
            '{0, 4095, 1, 1, 0},  '{1, 4000, 255, 1, 0}, '{0, 60, 60, 0, 60}, '{1, 119, 2, 1, 0}
        };
        rmode = 1;
        for (int v = 0; v < 12; v++) begin
            eb = beats_seen;
            ee = err_seen;
            post(vecs[v].id, vecs[v].base, vecs[v].len);
            wait_idle();
            chk($sformatf("vec%0d_err", v), 32'(err_seen - ee), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_beats", v), 32'(beats_seen - eb), 32'(vecs[v].exp_beats));
        end

        // Randomized traffic with random backpressure
        acc_prev = '0;
        for (int c = 0; c < 3000; c++) begin
            nxt();
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_valid[i] && acc_prev[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    b_arr[i] = WIDTH_A'($urandom_range(0, DEPTH + 4));
                    l_arr[i] = LEN_W'($urandom_range(0, 9));
                    req_valid[i] = 1'b1;
                end
            end
            mid();
            acc_prev = req_valid & req_ready;
        end
        nxt();
        req_valid = '0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

endmodule
